// File: rtl/team_06_input_ctrl.sv
// Front-panel input conditioner: synchronises and debounces pushbuttons
// (toggle or momentary per button) and decodes a quadrature volume encoder
// into a saturating volume value with one-cycle change/error strobes.
module team_06_input_ctrl #(
  parameter int               N_BTN       = 4,
  parameter int               DB_CYC      = 5000,
  parameter logic [N_BTN-1:0] TOGGLE_MASK = 4'b1110,
  parameter int               VOL_W       = 4,
  parameter int               VOL_INIT    = 0,
  parameter int               VOL_STEP    = 1,
  parameter int               ENC_DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] pbs,
  input  logic [1:0]       vol,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [VOL_W-1:0] volume,
  output logic             vol_change,
  output logic             enc_err
);

  // Debounce counter sized to hold DB_CYC; it only ever reaches DB_CYC-1.
  localparam int               CNT_W    = $clog2(DB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYC - 1);

  // Detent accumulator spans -(ENC_DIV-1)..+(ENC_DIV-1) plus a sign bit.
  localparam int                      ACC_W  = $clog2(ENC_DIV + 1) + 1;
  localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(ENC_DIV - 1);
  localparam logic signed [ACC_W-1:0] ACC_LO = -ACC_HI;

  // Volume arithmetic is done one bit wider so saturation is a plain compare.
  localparam logic [VOL_W:0]   VOL_MAX_X = {1'b0, {VOL_W{1'b1}}};
  localparam logic [VOL_W:0]   STEP_X    = (VOL_W + 1)'(VOL_STEP);
  localparam logic [VOL_W-1:0] VOL_RST   = VOL_W'(VOL_INIT);

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] pbs_s1_reg;
  logic [N_BTN-1:0] pbs_s2_reg;
  logic [1:0]       vol_s1_reg;
  logic [1:0]       vol_s2_reg;

  // Two-flop synchronisers for every asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pbs_s1_reg <= '0;
      pbs_s2_reg <= '0;
      vol_s1_reg <= 2'b00;
      vol_s2_reg <= 2'b00;
    end else begin
      pbs_s1_reg <= pbs;
      pbs_s2_reg <= pbs_s1_reg;
      vol_s1_reg <= vol;
      vol_s2_reg <= vol_s1_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Per-button debounce
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] stable_reg;
  logic [N_BTN-1:0] stable_next;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             stb_next;

    // Count consecutive cycles the synchronised input disagrees with the
    // accepted level; any agreement (a bounce back) restarts the count.
    always_comb begin
      cnt_next = cnt_reg;
      stb_next = stable_reg[gi];
      if (pbs_s2_reg[gi] == stable_reg[gi]) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
        stb_next = pbs_s2_reg[gi];
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    // Debounce counter register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_next;
      end
    end

    assign stable_next[gi] = stb_next;
  end

  // ---------------------------------------------------------------------
  // Button press / state outputs
  // ---------------------------------------------------------------------
  logic [N_BTN-1:0] stable_dly_reg;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] btn_press_reg;
  logic [N_BTN-1:0] btn_state_reg;
  logic [N_BTN-1:0] btn_state_next;

  // Rising edge of the debounced level, seen one cycle after it is accepted.
  assign rise = stable_reg & ~stable_dly_reg;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    // Toggle buttons flip on each press; momentary buttons mirror the
    // debounced level with the same one-cycle delay as the press strobe.
    assign btn_state_next[gi] = TOGGLE_MASK[gi] ? (btn_state_reg[gi] ^ rise[gi])
                                                : stable_reg[gi];
  end

  // Debounced level, its delayed copy, and the registered button outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_reg     <= '0;
      stable_dly_reg <= '0;
      btn_press_reg  <= '0;
      btn_state_reg  <= '0;
    end else begin
      stable_reg     <= stable_next;
      stable_dly_reg <= stable_reg;
      btn_press_reg  <= rise;
      btn_state_reg  <= btn_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Quadrature decoder and volume
  // ---------------------------------------------------------------------
  logic [1:0]              prv_reg;
  logic [1:0]              delta;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic                    detent_up;
  logic                    detent_dn;
  logic                    enc_err_reg;
  logic                    enc_err_next;
  logic [VOL_W-1:0]        volume_reg;
  logic [VOL_W-1:0]        volume_next;
  logic                    vol_change_reg;
  logic                    vol_change_next;
  logic [VOL_W:0]          vol_x;
  logic [VOL_W:0]          vol_sum;

  // Map the Gray code 00,01,11,10 to positions 0..3 so direction is a
  // modulo-4 difference: +1 clockwise, -1 anticlockwise, 2 is a skipped state.
  function automatic logic [1:0] gray_pos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  assign delta = gray_pos(vol_s2_reg) - gray_pos(prv_reg);

  // Detent accumulation: a detent fires when a step would push the
  // accumulator past +/-(ENC_DIV-1); reversals simply unwind it.
  always_comb begin
    acc_next     = acc_reg;
    detent_up    = 1'b0;
    detent_dn    = 1'b0;
    enc_err_next = 1'b0;
    case (delta)
      2'd1: begin
        if (acc_reg == ACC_HI) begin
          acc_next  = '0;
          detent_up = 1'b1;
        end else begin
          acc_next = acc_reg + 1'b1;
        end
      end
      2'd3: begin
        if (acc_reg == ACC_LO) begin
          acc_next  = '0;
          detent_dn = 1'b1;
        end else begin
          acc_next = acc_reg - 1'b1;
        end
      end
      2'd2: enc_err_next = 1'b1;
      default: ;
    endcase
  end

  assign vol_x   = {1'b0, volume_reg};
  assign vol_sum = vol_x + STEP_X;

  // Saturating volume update; the change strobe compares old and new value
  // so a detent at either limit produces no pulse.
  always_comb begin
    volume_next = volume_reg;
    if (detent_up) begin
      volume_next = (vol_sum > VOL_MAX_X) ? VOL_MAX_X[VOL_W-1:0] : vol_sum[VOL_W-1:0];
    end else if (detent_dn) begin
      volume_next = (vol_x < STEP_X) ? '0 : (volume_reg - STEP_X[VOL_W-1:0]);
    end
    vol_change_next = (volume_next != volume_reg);
  end

  // Encoder history, accumulator, volume and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prv_reg        <= 2'b00;
      acc_reg        <= '0;
      volume_reg     <= VOL_RST;
      vol_change_reg <= 1'b0;
      enc_err_reg    <= 1'b0;
    end else begin
      prv_reg        <= vol_s2_reg;
      acc_reg        <= acc_next;
      volume_reg     <= volume_next;
      vol_change_reg <= vol_change_next;
      enc_err_reg    <= enc_err_next;
    end
  end

  assign btn_state  = btn_state_reg;
  assign btn_press  = btn_press_reg;
  assign volume     = volume_reg;
  assign vol_change = vol_change_reg;
  assign enc_err    = enc_err_reg;

endmodule

// File: tb/tb_team_06_input_ctrl.sv
// Scoreboard bench for team_06_input_ctrl: stimulus pushes expected events
// (cycle, value) into queues; negedge monitors pop and compare on strobes.
module tb_team_06_input_ctrl;

  localparam int DB = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pbs = 4'b0000;
  logic [3:0] pbs4 = 4'b0000;
  logic [1:0] vol = 2'b00;
  logic [1:0] vol4 = 2'b00;

  logic [3:0] btn_state, btn_press, btn_state4, btn_press4;
  logic [3:0] volume, volume4;
  logic       vol_change, vol_change4, enc_err, enc_err4;

  team_06_input_ctrl #(
    .N_BTN(4), .DB_CYC(DB), .TOGGLE_MASK(4'b1110), .VOL_W(4),
    .VOL_INIT(0), .VOL_STEP(1), .ENC_DIV(1)
  ) dut (
    .clk(clk), .rst(rst), .pbs(pbs), .vol(vol),
    .btn_state(btn_state), .btn_press(btn_press), .volume(volume),
    .vol_change(vol_change), .enc_err(enc_err)
  );

  team_06_input_ctrl #(
    .N_BTN(4), .DB_CYC(DB), .TOGGLE_MASK(4'b1110), .VOL_W(4),
    .VOL_INIT(0), .VOL_STEP(3), .ENC_DIV(4)
  ) dut4 (
    .clk(clk), .rst(rst), .pbs(pbs4), .vol(vol4),
    .btn_state(btn_state4), .btn_press(btn_press4), .volume(volume4),
    .vol_change(vol_change4), .enc_err(enc_err4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic [3:0] press; logic [3:0] state; } btn_ev_t;
  typedef struct { int cyc; logic [3:0] v; } vol_ev_t;

  btn_ev_t btn_q[$];
  vol_ev_t vol_q[$];
  vol_ev_t vol4_q[$];
  int      err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected strobe actual=%0d required=no event (cycle %0d)", name, act, cyc);
  endtask

  // Monitors: pop the scoreboard whenever a strobe is presented.
  always @(negedge clk) begin
    btn_ev_t be;
    vol_ev_t ve;
    int      ec;
    if (!rst) begin
      if (btn_press !== 4'b0000) begin
        if (btn_q.size() == 0) unexpected("btn_press", btn_press);
        else begin
          be = btn_q.pop_front();
          chk("btn_cyc", cyc, be.cyc);
          chk("btn_press", btn_press, be.press);
          chk("btn_state", btn_state, be.state);
        end
      end
      if (vol_change !== 1'b0) begin
        if (vol_q.size() == 0) unexpected("vol_change", volume);
        else begin
          ve = vol_q.pop_front();
          chk("vol_cyc", cyc, ve.cyc);
          chk("volume", volume, ve.v);
        end
      end
      if (vol_change4 !== 1'b0) begin
        if (vol4_q.size() == 0) unexpected("vol_change4", volume4);
        else begin
          ve = vol4_q.pop_front();
          chk("vol4_cyc", cyc, ve.cyc);
          chk("volume4", volume4, ve.v);
        end
      end
      if (enc_err !== 1'b0) begin
        if (err_q.size() == 0) unexpected("enc_err", enc_err);
        else begin
          ec = err_q.pop_front();
          chk("enc_err_cyc", cyc, ec);
        end
      end
      if (enc_err4 !== 1'b0) unexpected("enc_err4", enc_err4);
      if (btn_press4 !== 4'b0000) unexpected("btn_press4", btn_press4);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  int pos = 0;
  int pos4 = 0;

  task automatic drive_a(input int dir, output int dc);
    pos += dir;
    vol = gray(pos);
    dc  = cyc;
  endtask

  task automatic drive_b(input int dir, output int dc);
    pos4 += dir;
    vol4 = gray(pos4);
    dc   = cyc;
  endtask

  task automatic queues_empty(input string tag);
    chk({tag, "_btn_q"}, btn_q.size(), 0);
    chk({tag, "_vol_q"}, vol_q.size(), 0);
    chk({tag, "_vol4_q"}, vol4_q.size(), 0);
    chk({tag, "_err_q"}, err_q.size(), 0);
  endtask

  // T4 table for the ENC_DIV=4 / VOL_STEP=3 instance; -1 means no pulse.
  int t4_dir[18] = '{1, 1, 1, -1, -1, 1, 1, 1, 1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
  int t4_exp[18] = '{-1, -1, -1, -1, -1, -1, -1, 3, -1, -1, -1, -1, -1, 0, -1, -1, -1, -1};

  initial begin
    int dc;
    int aw[3];
    int vexp;

    // Reset state
    tick(3);
    chk("rst_btn_state", btn_state, 4'b0000);
    chk("rst_btn_press", btn_press, 4'b0000);
    chk("rst_volume", volume, 0);
    chk("rst_vol_change", vol_change, 0);
    chk("rst_enc_err", enc_err, 0);
    chk("rst_volume4", volume4, 0);
    rst = 1'b0;
    tick(3);

    // T1: bounce shorter than DB on pbs[1], then a clean hold
    for (int k = 0; k < 20; k++) begin
      pbs[1] = ~pbs[1];
      tick(100);
    end
    chk("t1_bounce_state", btn_state, 4'b0000);
    pbs[1] = 1'b1;
    btn_q.push_back('{cyc + DB + 3, 4'b0010, 4'b0010});
    tick(DB + 10);
    chk("t1_state_pressed", btn_state, 4'b0010);
    pbs[1] = 1'b0;
    tick(DB + 10);
    chk("t1_state_released", btn_state, 4'b0010);
    queues_empty("t1");

    // T2: momentary pbs[0] and toggle pbs[2] pressed together
    pbs[0] = 1'b1;
    pbs[2] = 1'b1;
    btn_q.push_back('{cyc + DB + 3, 4'b0101, 4'b0111});
    tick(DB + 10);
    chk("t2_state_pressed", btn_state, 4'b0111);
    pbs[0] = 1'b0;
    pbs[2] = 1'b0;
    tick(DB + 10);
    chk("t2_state_released", btn_state, 4'b0110);
    pbs[2] = 1'b1;
    btn_q.push_back('{cyc + DB + 3, 4'b0100, 4'b0010});
    tick(DB + 10);
    pbs[2] = 1'b0;
    tick(DB + 10);
    chk("t2_state_second", btn_state, 4'b0010);
    queues_empty("t2");

    // T3: 20 CW saturate at 15, then 3 ACW down to 12
    for (int i = 1; i <= 20; i++) begin
      drive_a(1, dc);
      if (i <= 15) vol_q.push_back('{dc + 3, 4'(i)});
      tick(4);
    end
    chk("t3_volume_sat", volume, 15);
    aw = '{14, 13, 12};
    for (int i = 0; i < 3; i++) begin
      drive_a(-1, dc);
      vol_q.push_back('{dc + 3, 4'(aw[i])});
      tick(4);
    end
    chk("t3_volume_end", volume, 12);
    queues_empty("t3");

    // T5: one ACW to 11 (encoder at 00), illegal 00->11, then legal 11->10 CW
    drive_a(-1, dc);
    vol_q.push_back('{dc + 3, 4'd11});
    tick(4);
    pos = 2;
    vol = 2'b11;
    err_q.push_back(cyc + 3);
    tick(6);
    chk("t5_volume_after_err", volume, 11);
    drive_a(1, dc);
    vol_q.push_back('{dc + 3, 4'd12});
    tick(4);
    chk("t5_volume_after_cw", volume, 12);
    queues_empty("t5");

    // T4 on the divided instance
    for (int i = 0; i < 18; i++) begin
      drive_b(t4_dir[i], dc);
      vexp = t4_exp[i];
      if (vexp >= 0) vol4_q.push_back('{dc + 3, 4'(vexp)});
      tick(4);
      if (i == 8) chk("t4_volume_up", volume4, 3);
    end
    chk("t4_volume_end", volume4, 0);
    queues_empty("t4");

    // T6: bring volume to 9, set a toggle, start a debounce, then reset
    aw = '{11, 10, 9};
    for (int i = 0; i < 3; i++) begin
      drive_a(-1, dc);
      vol_q.push_back('{dc + 3, 4'(aw[i])});
      tick(4);
    end
    chk("t6_volume_pre", volume, 9);
    pbs[2] = 1'b1;
    btn_q.push_back('{cyc + DB + 3, 4'b0100, 4'b0110});
    tick(DB + 10);
    pbs[2] = 1'b0;
    tick(DB + 10);
    chk("t6_state_pre", btn_state, 4'b0110);
    pbs[0] = 1'b1;
    tick(DB / 2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_btn_state", btn_state, 4'b0000);
    chk("t6_async_btn_press", btn_press, 4'b0000);
    chk("t6_async_volume", volume, 0);
    chk("t6_async_vol_change", vol_change, 0);
    chk("t6_async_enc_err", enc_err, 0);
    pbs = 4'b0000;
    tick(3);
    rst = 1'b0;
    tick(2 * DB + 10);
    chk("t6_btn_state_after", btn_state, 4'b0000);
    chk("t6_volume_after", volume, 0);
    chk("t6_btn_state4", btn_state4, 4'b0000);
    queues_empty("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
